// File: rtl/btn_sched_pkg.sv
// Shared definitions for the button command scheduler: debounce FSM state
// encodings and a width helper used for cmd_id and the tick counter.
package btn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } btn_state_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-driven debounce FSM and, when
// BTN_SCHED_REPEAT_EN is defined, an auto-repeat counter active while held.
module debounce_channel
    import btn_sched_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_TICKS = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = width_of(STABLE_TICKS);

    if (STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_cfg
        $error("debounce_channel: STABLE_TICKS and REPEAT_TICKS must be >= 1");
    end

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

`ifdef BTN_SCHED_REPEAT_EN
    localparam int RPT_W = width_of(REPEAT_TICKS);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
`ifdef BTN_SCHED_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = ST_HELD;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            state_d = ST_ARMING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (!sync2_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
                        state_d = ST_HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = ST_IDLE;
                            level_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
`ifdef BTN_SCHED_REPEAT_EN
                    else if (rpt_q == RPT_W'(REPEAT_TICKS - 1)) begin
                        rpt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    if (sync2_q) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        level_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
`ifdef BTN_SCHED_REPEAT_EN
        // Any exit from HELD, even a one-tick glitch, restarts the repeat interval.
        if (state_d != ST_HELD) begin
            rpt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
`ifdef BTN_SCHED_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
`ifdef BTN_SCHED_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/button_cmd_scheduler.sv
// Debounces N_CH buttons on a shared sample tick and turns each press into a
// round-robin arbitrated command. Define BTN_SCHED_REPEAT_EN for auto-repeat.
module button_cmd_scheduler
    import btn_sched_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 1024,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_TICKS = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          btn_raw,
    output logic [N_CH-1:0]          btn_level,
    output logic                     cmd_valid,
    output logic [$clog2(N_CH)-1:0]  cmd_id,
    input  logic                     cmd_ready,
    output logic [N_CH-1:0]          cmd_ovf
);

    localparam int ID_W   = width_of(N_CH);
    localparam int TICK_W = width_of(TICK_DIV);

    if (N_CH < 2 || TICK_DIV < 2) begin : g_bad_cfg
        $error("button_cmd_scheduler: N_CH and TICK_DIV must be >= 2");
    end

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [N_CH-1:0]   press_w;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
    logic              load;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;

    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .btn_raw (btn_raw[g]),
            .level   (btn_level[g]),
            .press   (press_w[g])
        );
    end

    // Output handshake: cmd_valid/cmd_id are held stable until the cycle in
    // which cmd_valid & cmd_ready are both high; that cycle is the transfer.
    assign load = !cmd_valid_q || cmd_ready;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_CH;
            if (!grant_found && pending_q[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        pending_d   = pending_q;
        ovf_d       = ovf_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        if (load) begin
            cmd_valid_d = grant_found;
            if (grant_found) begin
                cmd_id_d             = grant_idx;
                pending_d[grant_idx] = 1'b0;
                rr_ptr_d = (grant_idx == ID_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
        // A new press overrides a same-cycle grant clear; only a press onto a
        // pending bit that is not being drained counts as dropped.
        for (int c = 0; c < N_CH; c++) begin
            if (press_w[c]) begin
                if (pending_q[c] && !(load && grant_found && grant_idx == ID_W'(c))) begin
                    ovf_d[c] = 1'b1;
                end
                pending_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_ovf   = ovf_q;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Scoreboard bench for button_cmd_scheduler with a small tick divider.
module tb_button_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       cmd_ready;
    logic [3:0] cmd_ovf;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    button_cmd_scheduler #(
        .N_CH         (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .REPEAT_TICKS (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .cmd_ready (cmd_ready),
        .cmd_ovf   (cmd_ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: every accepted command is popped and compared
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected actual=%0d required=none", cmd_id);
            end else begin
                check("cmd_id", {30'd0, cmd_id}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst_n     = 1'b0;
        btn_raw   = 4'h0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_level", {28'd0, btn_level}, 32'h0);
        check("rst_valid", {31'd0, cmd_valid}, 32'h0);
        check("rst_id",    {30'd0, cmd_id},    32'h0);
        check("rst_ovf",   {28'd0, cmd_ovf},   32'h0);
        rst_n = 1'b1;
    endtask

    task automatic wait_level(input string name, input int ch, input logic val, input int budget);
        int n = 0;
        while (btn_level[ch] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, btn_level[ch]}, {31'd0, val});
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, cmd_valid}, 32'h1);
    endtask

    task automatic press_ch(input int ch);
        btn_raw[ch] = 1'b1;
        wait_level("press_level_hi", ch, 1'b1, 60);
        btn_raw[ch] = 1'b0;
        wait_level("press_level_lo", ch, 1'b0, 60);
    endtask

    initial begin
        int bad;
        do_reset();

        // bounce on ch1: never three consecutive matching ticks
        cmd_ready = 1'b1;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            if (k % 3 == 0) btn_raw[1] = ~btn_raw[1];
        end
        btn_raw[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("bounce_level_low", {31'd0, btn_level[1]}, 32'h0);
        exp_q.push_back(2'd1);
        btn_raw[1] = 1'b1;
        repeat (8) @(negedge clk);
        check("bounce_no_early", {31'd0, btn_level[1]}, 32'h0);
        wait_level("bounce_level_hi", 1, 1'b1, 40);
        btn_raw[1] = 1'b0;
        wait_level("bounce_release", 1, 1'b0, 60);

        // simultaneous press from a fresh reset: ids stream 0,1,2,3
        do_reset();
        cmd_ready = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        btn_raw = 4'hF;
        wait_valid("simul_valid", 60);
        for (int k = 0; k < 4; k++) begin
            check("simul_stream", {31'd0, cmd_valid}, 32'h1);
            @(negedge clk);
        end
        check("simul_drained", {31'd0, cmd_valid}, 32'h0);
        check("simul_levels", {28'd0, btn_level}, 32'hF);
        btn_raw = 4'h0;
        for (int c = 0; c < 4; c++) wait_level("simul_release", c, 1'b0, 60);
        exp_q.push_back(2'd2);
        press_ch(2);

        // backpressure on ch3
        repeat (6) @(negedge clk);
        cmd_ready = 1'b0;
        exp_q.push_back(2'd3);
        press_ch(3);
        wait_valid("bp_valid", 20);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (cmd_valid !== 1'b1 || cmd_id !== 2'd3) bad++;
            @(negedge clk);
        end
        check("bp_stable", bad, 32'h0);
        exp_q.push_back(2'd3);
        press_ch(3);
        check("bp_no_ovf_second", {28'd0, cmd_ovf}, 32'h0);
        press_ch(3);
        check("bp_ovf_third", {28'd0, cmd_ovf}, 32'h8);
        cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_delivered", exp_q.size(), 32'h0);
        check("bp_idle", {31'd0, cmd_valid}, 32'h0);

        // release glitch of one tick on held ch0
        exp_q.push_back(2'd0);
        btn_raw[0] = 1'b1;
        wait_level("glitch_level_hi", 0, 1'b1, 60);
        repeat (4) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (4) @(negedge clk);
        btn_raw[0] = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (btn_level[0] !== 1'b1) bad++;
            @(negedge clk);
        end
        check("glitch_held", bad, 32'h0);
        btn_raw[0] = 1'b0;
        wait_level("glitch_release", 0, 1'b0, 60);
        repeat (6) @(negedge clk);
        check("glitch_one_cmd", exp_q.size(), 32'h0);

        // ch2 held for 30 ticks
        exp_q.push_back(2'd2);
`ifdef BTN_SCHED_REPEAT_EN
        for (int k = 0; k < 5; k++) exp_q.push_back(2'd2);
`endif
        btn_raw[2] = 1'b1;
        repeat (120) @(negedge clk);
        btn_raw[2] = 1'b0;
        wait_level("repeat_release", 2, 1'b0, 60);
        repeat (10) @(negedge clk);
        check("repeat_count", exp_q.size(), 32'h0);

        // reset while a command waits in the output register
        cmd_ready = 1'b0;
        press_ch(1);
        wait_valid("midrst_valid", 20);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_clr", {31'd0, cmd_valid}, 32'h0);
        check("midrst_ovf_clr", {28'd0, cmd_ovf}, 32'h0);
        check("midrst_level", {28'd0, btn_level}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_lost", {31'd0, cmd_valid}, 32'h0);

        check("final_queue_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
